// File: rtl/fc_weight_addr_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : fc_weight_addr_gen_multi
// Purpose  : Weight-address generator for the fully-connected layer. Emits
//            NPORT consecutive weight-RAM addresses per enabled cycle, walking
//            the OUTNEURON*INNEURON/PO weight words of one pass from a
//            runtime base address. The pass repeats num_pass times per job.
//            Each job opens with a start pulse and closes with a done pulse.
// Revision : 1.0 - initial multi-port, multi-pass release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   start      in   one-cycle job request, honoured only while idle
//   enable     in   advance permission; low stalls the generator
//   base       in   weight base address, latched on an accepted start
//   num_pass   in   passes per job, latched on start (0 behaves as 1)
//   addr_out   out  lane k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   addr_valid out  addr_out carries a new address group this cycle
//   pass_last  out  current group closes a pass
//   done       out  current group closes the job (one-cycle pulse)
//   busy       out  job in progress, up to and including the done cycle
// ============================================================================
module fc_weight_addr_gen_multi #(
  parameter int ADDR_WIDTH = 16,
  parameter int OUTNEURON  = 4,
  parameter int INNEURON   = 8,
  parameter int PO         = 2,
  parameter int NPORT      = 2,
  parameter int PASS_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        enable,
  input  logic [ADDR_WIDTH-1:0]       base,
  input  logic [PASS_WIDTH-1:0]       num_pass,
  output logic [NPORT*ADDR_WIDTH-1:0] addr_out,
  output logic                        addr_valid,
  output logic                        pass_last,
  output logic                        done,
  output logic                        busy
);

  localparam int TOTAL = OUTNEURON * INNEURON / PO;

  // Index of the first word of the final group in a pass.
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TOTAL - NPORT);
  localparam logic [ADDR_WIDTH-1:0] IDX_STEP = ADDR_WIDTH'(NPORT);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // --------------------------------------------------------------------------
  generate
    if (PO < 1 || ((OUTNEURON * INNEURON) % PO) != 0) begin : g_bad_po
      $fatal(1, "fc_weight_addr_gen_multi: PO must divide OUTNEURON*INNEURON");
    end
    if (NPORT < 1 || TOTAL < NPORT || (TOTAL % NPORT) != 0) begin : g_bad_nport
      $fatal(1, "fc_weight_addr_gen_multi: TOTAL must be a non-zero multiple of NPORT");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                      state_q,      state_d;
  logic [ADDR_WIDTH-1:0]       idx_q,        idx_d;
  logic [PASS_WIDTH-1:0]       pass_cnt_q,   pass_cnt_d;
  logic [ADDR_WIDTH-1:0]       base_q,       base_d;
  logic [PASS_WIDTH-1:0]       npass_q,      npass_d;
  logic [NPORT*ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic                        valid_q,      valid_d;
  logic                        pass_last_q,  pass_last_d;
  logic                        done_q,       done_d;
  logic                        busy_q,       busy_d;

  // --------------------------------------------------------------------------
  // Lane addresses for the group at the current index; the sum wraps
  // naturally modulo 2^ADDR_WIDTH.
  // --------------------------------------------------------------------------
  logic [NPORT*ADDR_WIDTH-1:0] lanes_w;

  generate
    for (genvar k = 0; k < NPORT; k++) begin : g_lane
      assign lanes_w[k*ADDR_WIDTH +: ADDR_WIDTH] = base_q + idx_q + ADDR_WIDTH'(k);
    end
  endgenerate

  // One extra bit so the comparison against the latched pass count cannot
  // alias when pass_cnt_q sits at its maximum representable value.
  logic [PASS_WIDTH:0] pass_nxt_w;
  logic                last_group_w;
  logic                last_pass_w;

  assign pass_nxt_w   = {1'b0, pass_cnt_q} + (PASS_WIDTH+1)'(1);
  assign last_group_w = (idx_q == LAST_IDX);
  assign last_pass_w  = (pass_nxt_w == {1'b0, npass_q});

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pass_cnt_d  = pass_cnt_q;
    base_d      = base_q;
    npass_d     = npass_q;
    addr_d      = addr_q;
    valid_d     = 1'b0;
    pass_last_d = 1'b0;
    done_d      = 1'b0;
    busy_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The done cycle is already in IDLE but still reports busy; a start
        // there is not taken, so a restart lands the cycle after busy drops.
        if (start && !busy_q) begin
          state_d    = ST_RUN;
          base_d     = base;
          npass_d    = (num_pass == '0) ? PASS_WIDTH'(1) : num_pass;
          idx_d      = '0;
          pass_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end

      ST_RUN: begin
        busy_d = 1'b1;
        if (enable) begin
          addr_d  = lanes_w;
          valid_d = 1'b1;
          if (last_group_w) begin
            pass_last_d = 1'b1;
            idx_d       = '0;
            pass_cnt_d  = pass_nxt_w[PASS_WIDTH-1:0];
            if (last_pass_w) begin
              done_d     = 1'b1;
              pass_cnt_d = '0;
              state_d    = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_STEP;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pass_cnt_q  <= '0;
      base_q      <= '0;
      npass_q     <= '0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      pass_last_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pass_cnt_q  <= pass_cnt_d;
      base_q      <= base_d;
      npass_q     <= npass_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      pass_last_q <= pass_last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign addr_out   = addr_q;
  assign addr_valid = valid_q;
  assign pass_last  = pass_last_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_weight_addr_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_weight_addr_gen_multi
// Purpose  : Self-checking bench for fc_weight_addr_gen_multi. Two instances
//            share clock and reset: dut_a with NPORT=2 and dut_b with NPORT=4.
//            Expected groups are computed arithmetically from group number,
//            base and pass count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_weight_addr_gen_multi;

  localparam int AW    = 16;
  localparam int TOTAL = 16;

  logic clk = 1'b0;
  logic reset;

  logic            start_a, en_a, start_b, en_b;
  logic [AW-1:0]   base_a, base_b;
  logic [7:0]      np_a, np_b;
  logic [2*AW-1:0] addr_a;
  logic [4*AW-1:0] addr_b;
  logic            valid_a, pl_a, done_a, busy_a;
  logic            valid_b, pl_b, done_b, busy_b;

  int checks = 0;
  int errors = 0;
  logic [63:0] hold [2];

  always #5 clk = ~clk;

  fc_weight_addr_gen_multi #(.NPORT(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .enable(en_a),
    .base(base_a), .num_pass(np_a), .addr_out(addr_a),
    .addr_valid(valid_a), .pass_last(pl_a), .done(done_a), .busy(busy_a)
  );

  fc_weight_addr_gen_multi #(.NPORT(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .enable(en_b),
    .base(base_b), .num_pass(np_b), .addr_out(addr_b),
    .addr_valid(valid_b), .pass_last(pl_b), .done(done_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] g_addr(input int sel);
    return (sel != 0) ? addr_b : {32'd0, addr_a};
  endfunction
  function automatic logic g_valid(input int sel); return (sel != 0) ? valid_b : valid_a; endfunction
  function automatic logic g_pl(input int sel);    return (sel != 0) ? pl_b    : pl_a;    endfunction
  function automatic logic g_done(input int sel);  return (sel != 0) ? done_b  : done_a;  endfunction
  function automatic logic g_busy(input int sel);  return (sel != 0) ? busy_b  : busy_a;  endfunction

  task automatic drive(input int sel, input logic st, input logic en,
                       input logic [AW-1:0] b, input logic [7:0] np);
    if (sel != 0) begin
      start_b = st; en_b = en; base_b = b; np_b = np;
    end else begin
      start_a = st; en_a = en; base_a = b; np_a = np;
    end
  endtask

  // Expected lane vector for global group number g of a job.
  function automatic logic [63:0] exp_lanes(input int nport, input logic [AW-1:0] b, input int g);
    logic [63:0] e;
    int groups;
    e = '0;
    groups = TOTAL / nport;
    for (int k = 0; k < nport; k++)
      e[k*AW +: AW] = 16'(int'(b) + (g % groups) * nport + k);
    return e;
  endfunction

  task automatic check_idle(input int sel, input string tag, input logic [63:0] exp_addr, input logic exp_busy);
    chk({tag, "_valid"}, 64'(g_valid(sel)), 64'(0));
    chk({tag, "_pass_last"}, 64'(g_pl(sel)), 64'(0));
    chk({tag, "_done"}, 64'(g_done(sel)), 64'(0));
    chk({tag, "_busy"}, 64'(g_busy(sel)), 64'(exp_busy));
    chk({tag, "_addr"}, g_addr(sel), exp_addr);
  endtask

  // mode 0: enable always high; 1: random enable; 2: stall 3 cycles after group 2.
  // extra: pulse start mid-job. abort: return right after that many groups.
  task automatic run_job(input int sel, input logic [AW-1:0] b, input logic [7:0] np,
                         input int mode, input bit extra, input int abort);
    int nport, groups, npe, total, issued, stalled;
    bit finished, en;
    logic [63:0] e;
    nport    = (sel != 0) ? 4 : 2;
    groups   = TOTAL / nport;
    npe      = (np == 0) ? 1 : int'(np);
    total    = groups * npe;
    issued   = 0;
    stalled  = 0;
    finished = 0;

    drive(sel, 1'b1, 1'($urandom), b, np);
    step();
    check_idle(sel, "start", hold[sel], 1'b1);

    for (int cyc = 0; cyc < total * 8 + 40 && !finished; cyc++) begin
      if (mode == 0) en = 1'b1;
      else if (mode == 1) en = ($urandom_range(0, 3) != 0);
      else if (issued == 2 && stalled < 3) begin en = 1'b0; stalled++; end
      else en = 1'b1;
      drive(sel, extra && (issued == 3), en, 16'($urandom), 8'($urandom));
      step();
      if (en) begin
        e = exp_lanes(nport, b, issued);
        chk("grp_valid", 64'(g_valid(sel)), 64'(1));
        chk("grp_addr", g_addr(sel), e);
        chk("grp_pass_last", 64'(g_pl(sel)), 64'((issued % groups) == groups - 1));
        chk("grp_done", 64'(g_done(sel)), 64'(issued == total - 1));
        chk("grp_busy", 64'(g_busy(sel)), 64'(1));
        hold[sel] = e;
        issued++;
        if (issued == total) finished = 1;
        else if (abort > 0 && issued == abort) return;
      end else begin
        check_idle(sel, "stall", hold[sel], 1'b1);
      end
    end
    chk("job_complete", 64'(finished), 64'(1));

    drive(sel, 1'b0, 1'b0, 16'($urandom), 8'($urandom));
    step();
    check_idle(sel, "after_done", hold[sel], 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    hold[0] = '0;
    hold[1] = '0;
    step();
    step();
    check_idle(0, "reset_a", 64'd0, 1'b0);
    check_idle(1, "reset_b", 64'd0, 1'b0);
    reset = 1'b0;
    step();

    // Single pass, base 0x100, enable held.
    run_job(0, 16'h0100, 8'd1, 0, 1'b0, 0);
    // Three passes back to back, base 0 (restart in the cycle busy drops).
    run_job(0, 16'h0000, 8'd3, 0, 1'b0, 0);
    // Directed stall after group 2.
    run_job(0, 16'h0000, 8'd1, 2, 1'b0, 0);

    // Asynchronous reset mid-pass after group 5.
    run_job(0, 16'h0040, 8'd2, 0, 1'b0, 5);
    #3;
    reset = 1'b1;
    #1;
    check_idle(0, "async_reset_a", 64'd0, 1'b0);
    check_idle(1, "async_reset_b", 64'd0, 1'b0);
    hold[0] = '0;
    hold[1] = '0;
    drive(0, 1'b0, 1'b1, '0, '0);
    step();
    check_idle(0, "reset_held", 64'd0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle(0, "post_reset_idle", 64'd0, 1'b0);
    end
    run_job(0, 16'h0200, 8'd1, 0, 1'b0, 0);

    // num_pass 0 behaves as one pass; mid-job start ignored.
    run_job(0, 16'h0300, 8'd0, 0, 1'b1, 0);

    // Base wrap on both lane counts.
    run_job(0, 16'hFFFC, 8'd1, 0, 1'b0, 0);
    run_job(1, 16'hFFFC, 8'd1, 0, 1'b0, 0);
    run_job(1, 16'hFFFA, 8'd2, 1, 1'b1, 0);

    // Randomised jobs with random enable gaps.
    for (int j = 0; j < 8; j++)
      run_job(j % 2, 16'($urandom), 8'($urandom_range(0, 3)), 1, 1'($urandom), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fc_weight_addr_gen_multi.md
# fc_weight_addr_gen_multi

Parametrised weight-address generator for the fully-connected layer. It feeds NPORT weight-RAM read ports per cycle and steps through the layer's OUTNEURON*INNEURON/PO weight words from a runtime base address. A pass can repeat a programmable number of times, and each job starts and ends with a start/done handshake. It sits between the FC controller and the weight BRAM bank, replacing the fixed two-port, free-running generator.

## Interface
Parameters:
- ADDR_WIDTH, 16: width of each address lane and of base.
- OUTNEURON, 4: output neurons in the layer.
- INNEURON, 8: input neurons in the layer.
- PO, 2: output-parallelism divisor. TOTAL = OUTNEURON*INNEURON/PO words per pass.
- NPORT, 2: address lanes per cycle. TOTAL must be divisible by NPORT (elaboration-time check, fatal on failure).
- PASS_WIDTH, 8: width of the pass-count input.

Ports:
- clk  in  1  clock; reset reset, asynchronous, active-high; clock clk.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle job request; sampled only in IDLE.
- enable  in  1  advance permission; low stalls the generator.
- base  in  ADDR_WIDTH  weight base address; latched on accepted start.
- num_pass  in  PASS_WIDTH  passes per job; latched on start; 0 is treated as 1.
- addr_out  out  NPORT*ADDR_WIDTH  lane k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- addr_valid  out  1  addr_out carries a new address group this cycle.
- pass_last  out  1  the current group is the final group of a pass.
- done  out  1  the current group is the final group of the job (one-cycle pulse).
- busy  out  1  high from the cycle after the accepted start through the cycle done is visible.

## Operation
- FSM states: IDLE, RUN.
  - IDLE -> RUN: on start=1. Latch base and num_pass, clear idx and pass_cnt.
  - RUN -> IDLE: on the enabled cycle that issues the final group of the final pass.
- idx counter: width ADDR_WIDTH. Counts 0, NPORT, 2*NPORT, ..., TOTAL-NPORT, then wraps to 0.
- Group issue: each RUN cycle with enable=1 registers lane k = base_l + idx + k, truncated modulo 2^ADDR_WIDTH, sets addr_valid=1, and advances idx by NPORT.
- End of pass: when idx==TOTAL-NPORT, the issued group also sets pass_last=1, idx wraps to 0, and pass_cnt increments.
  - If pass_cnt+1 == max(num_pass_l,1): done=1 on that same group and the FSM returns to IDLE.
- Stall: in RUN with enable=0, idx and pass_cnt hold, addr_valid=0, and addr_out holds its last value.
- In IDLE: addr_valid, pass_last, and done are 0; addr_out holds its last value.
- start while in RUN is ignored. base and num_pass changes during RUN have no effect.
- Reset (at any time, including mid-pass): state=IDLE, idx=0, pass_cnt=0, addr_out=0, addr_valid=0, pass_last=0, done=0, busy=0. It takes effect immediately (asynchronous) and outputs stay 0 while reset is held.

## Timing
- Start at edge t moves the FSM to RUN and busy=1 after edge t.
- The first enabled RUN cycle ends at edge t+1. Group 0 is visible with addr_valid=1 after edge t+1.
- Throughput: one group per enabled cycle, no bubbles between passes.
- Each group is valid one cycle after the enabled cycle that produced it (registered output, latency 1).
- done and pass_last are aligned with the group they qualify, and each lasts exactly one cycle.
- busy falls one cycle after done is visible. A new start is accepted in the cycle busy is low, so the earliest back-to-back restart is done at cycle n, start at cycle n+1.
- All outputs are registered; none are combinational from inputs.

## Test plan
- Single pass, defaults (TOTAL=16, NPORT=2), base=0x100, num_pass=1, enable held high -> 8 consecutive groups (0x100,0x101) ... (0x10E,0x10F). pass_last and done on the 8th group. busy low the next cycle.
- num_pass=3, base=0 -> 24 groups; idx wraps to (0,1) with no gap; pass_last on groups 8, 16, 24; done only on group 24.
- Stall: enable low for 3 cycles after group 2 -> addr_valid=0 for those 3 cycles, addr_out holds (2,3), and the next valid group is (4,5) with no group lost.
- Reset asserted asynchronously mid-pass after group 5 -> all outputs 0 immediately. After release, with no start, the generator stays IDLE with addr_valid=0. A new start gives group 0 from the new base.
- num_pass=0 and a start pulse during RUN -> job runs as 1 pass; the extra start is ignored (exactly 8 groups, a single done).
- Base wrap: ADDR_WIDTH=16, base=0xFFFC -> lanes are 0xFFFC, 0xFFFD, 0xFFFE, 0xFFFF, 0x0000, ..., wrapping modulo 2^16. NPORT=4 rerun -> 4 groups per pass, lanes contiguous.
